// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and elaboration-time helpers for the seq_det detector.
// Provides the state-width helper and the constant function that builds the
// next-state table (KMP-style longest-prefix fallback) from the pattern parameters.
package seq_det_pkg;

  localparam int MIN_PAT_LEN = 2;
  localparam int MAX_PAT_LEN = 8;

  // One table entry holds a state code; 4 bits covers M0..M7 plus DET=8.
  typedef logic [3:0] st_t;

  // Indexed by {state, bit}. Sized for the widest state register (4 bits) so
  // unused state encodings always land on a defined entry (zero -> M0).
  localparam int TAB_DEPTH = 32;
  typedef st_t [TAB_DEPTH-1:0] ns_tab_t;

  // State code k (0..PAT_LEN-1) is Mk; code PAT_LEN is DET.
  function automatic int state_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Pattern bit i in arrival order (i=0 is the first bit received = MSB).
  function automatic logic pat_bit(input logic [7:0] pattern, input int pat_len, input int i);
    return pattern[3'(pat_len - 1 - i)];
  endfunction

  function automatic ns_tab_t build_table(input int pat_len, input logic [7:0] pattern,
                                          input bit overlap);
    ns_tab_t    tab;
    logic [8:0] str;
    int         best;
    bit         ok;
    logic       bb;
    tab = '0;
    for (int s = 0; s <= pat_len; s++) begin
      for (int b = 0; b < 2; b++) begin
        bb  = b[0];
        str = '0;
        best = 0;
        if (s == pat_len && !overlap) begin
          // Non-overlapping: history is wiped after a detect.
          best = (bb == pat_bit(pattern, pat_len, 0)) ? 1 : 0;
        end else begin
          // History is the matched prefix (the whole pattern for DET) plus the new bit.
          for (int j = 0; j < s; j++) str[4'(j)] = pat_bit(pattern, pat_len, j);
          str[4'(s)] = bb;
          // Longest prefix of the pattern that is a suffix of the history.
          for (int k = 1; k <= s + 1 && k <= pat_len; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
              if (str[4'(s + 1 - k + i)] != pat_bit(pattern, pat_len, i)) ok = 1'b0;
            end
            if (ok) best = k;
          end
        end
        tab[5'(2 * s + b)] = st_t'(best);
      end
    end
    return tab;
  endfunction

endpackage

// File: rtl/seq_det.sv
// seq_det: serial bit-pattern detector (Moore FSM), one bit sampled per rising clk edge.
// Ports: clk (clock), rst (sync active-high reset), In (serial bit), Out (one-cycle detect flag).
// Out is decoded from the state register only, so it has no combinational path from In.
module seq_det #(
  parameter int PAT_LEN = 4,
  parameter     PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic In,
  output logic Out
);
  import seq_det_pkg::*;

  if (PAT_LEN < MIN_PAT_LEN || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
    $error("seq_det: PAT_LEN must be in 2..8");
  end
  if ($bits(PATTERN) != PAT_LEN) begin : g_bad_pat
    $error("seq_det: PATTERN width must equal PAT_LEN");
  end

  localparam int              SW     = state_width(PAT_LEN);
  localparam logic [SW-1:0]   DET    = SW'(PAT_LEN);
  localparam ns_tab_t         NS_TAB = build_table(PAT_LEN, 8'(PATTERN), OVERLAP);

  logic [SW-1:0] state;
  logic [4:0]    idx;

  assign idx = 5'({state, In});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= SW'(NS_TAB[idx]);
    end
  end

  assign Out = (state == DET);

endmodule

// File: tb/tb_seq_det.sv
// tb_seq_det: directed and random checks of seq_det, overlap and non-overlap builds.
// Ports: none (bench top); drives a shared clk/rst/In into two DUT instances.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_det;

  logic clk;
  logic rst;
  logic In;
  logic out_ov;
  logic out_no;

  int checks   = 0;
  int failures = 0;

  seq_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .In(In), .Out(out_ov)
  );

  seq_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .In(In), .Out(out_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one bit, clock it in, and settle just past the edge.
  task automatic step(input logic b);
    In = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'($urandom_range(0, 1)));
    rst = 1'b0;
  endtask

  // Drive a bit stream and compare both outputs after each edge.
  task automatic run_stream(input string tag, input int n, input logic [7:0] bits,
                            input logic [7:0] exp_ov, input logic [7:0] exp_no);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i]);
      check($sformatf("%s_ov_e%0d", tag, n - i), {3'b0, out_ov}, {3'b0, exp_ov[i]});
      check($sformatf("%s_no_e%0d", tag, n - i), {3'b0, out_no}, {3'b0, exp_no[i]});
    end
  endtask

  initial begin
    logic [3:0] hist;
    int         cnt;
    logic       b;
    logic       exp;

    rst = 1'b1;
    In  = 1'b0;

    // Reset held for 3 edges with random input.
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)));
      check($sformatf("rst_out_ov_%0d", i), {3'b0, out_ov}, 4'h0);
      check($sformatf("rst_out_no_%0d", i), {3'b0, out_no}, 4'h0);
      check($sformatf("rst_state_%0d", i), {1'b0, dut_ov.state}, 4'h0);
    end
    rst = 1'b0;

    // Single match, then a trailing 0 clears the flag.
    run_stream("single", 5, 8'b0001_0110, 8'b0000_0010, 8'b0000_0010);

    // Overlapping stream 1011011.
    do_reset();
    run_stream("overlap", 7, 8'b0101_1011, 8'b0000_1001, 8'b0000_1000);

    // Fallback paths M1->M1 and M3->M2: 1101011.
    do_reset();
    run_stream("fallback", 7, 8'b0110_1011, 8'b0000_0001, 8'b0000_0001);

    // Reset mid-match discards the partial 101.
    do_reset();
    run_stream("mid_pre", 3, 8'b0000_0101, 8'b0000_0000, 8'b0000_0000);
    rst = 1'b1;
    step(1'b1);
    check("mid_rst_out", {3'b0, out_ov}, 4'h0);
    check("mid_rst_state", {1'b0, dut_ov.state}, 4'h0);
    rst = 1'b0;
    run_stream("mid_post", 5, 8'b0001_1011, 8'b0000_0001, 8'b0000_0001);

    // Reset in the cycle after a detect drops Out at that edge.
    rst = 1'b1;
    step(1'b1);
    check("det_rst_out_ov", {3'b0, out_ov}, 4'h0);
    check("det_rst_out_no", {3'b0, out_no}, 4'h0);
    rst = 1'b0;

    // Random stream with glitches between edges, checked against a shift-register model.
    hist = '0;
    cnt  = 0;
    for (int i = 0; i < 500; i++) begin
      b  = 1'($urandom_range(0, 1));
      In = 1'($urandom_range(0, 1));
      #3;
      In = 1'($urandom_range(0, 1));
      #3;
      In = b;
      @(posedge clk);
      #1;
      In   = ~b;
      hist = {hist[2:0], b};
      cnt++;
      exp  = (cnt >= 4) && (hist == 4'b1011);
      check($sformatf("rand_%0d", i), {3'b0, out_ov}, {3'b0, exp});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det.md
# seq_det

Serial bit-pattern detector. Samples one input bit per rising clock edge and asserts a one-cycle flag each time the most recent bits match a fixed pattern. Moore FSM, overlapping matches by default. Used as a leaf block on a serial control/data line.

## Interface
- `PAT_LEN`, default 4: pattern length in bits, 2..8.
- `PATTERN`, default 4'b1011: target sequence, MSB received first.
- `OVERLAP`, default 1: 1 allows overlapping matches; 0 restarts the search after each detect.

Ports:
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `In`   in  1  serial data bit, sampled on each rising edge of `clk`.
- `Out`  out 1  detect flag, high for one cycle per match.

## Operation
- `In` is sampled only at rising edges. It may change at any time between edges; the block has no synchronizer.
- State is the count of pattern bits matched so far, `M0`..`M(PAT_LEN-1)`, plus one terminal state `DET`.
  - `M0` is the reset and idle state.
  - `Mk` means the last k bits equal the first k bits of `PATTERN`.
- On each edge, take the current matched prefix and append the new bit. The next state is the longest prefix of `PATTERN` that is a suffix of that bit string, with standard failure-function (KMP) fallback.
  - If the full pattern matches, the next state is `DET`.
- Leaving `DET`:
  - `OVERLAP`=1: the matched pattern is the history; apply the same longest-prefix rule.
  - `OVERLAP`=0: history is empty; the next state is `M1` if the bit equals `PATTERN[PAT_LEN-1]`, else `M0`.
- Default transitions (`1011`, overlap):
  - `M0`: 1→`M1`, 0→`M0`
  - `M1`: 0→`M2`, 1→`M1`
  - `M2`: 1→`M3`, 0→`M0`
  - `M3`: 1→`DET`, 0→`M2`
  - `DET`: 1→`M1`, 0→`M2`
- Non-overlap `DET` transitions: 1→`M1`, 0→`M0`.
- `Out` = (state == `DET`). It is decoded only from the state register, so it is glitch-free with no combinational path from `In`.
- Reset: `rst`=1 at an edge forces state to `M0` and `Out` to 0. Reset has priority over `In`.
  - A partial match in progress when reset arrives is discarded.
  - After reset the bit history is empty.
- The transition table is a pure function of parameters and is computed at elaboration. No runtime configuration.

## Timing
- Latency: the last pattern bit is sampled at edge N; `Out` is high from edge N until edge N+1.
- `Out` is high for exactly one cycle per match, unless the next match also completes at edge N+1. That is impossible for `1011`, but possible for patterns such as `11` with `OVERLAP`=1, where `Out` stays high on consecutive cycles.
- Minimum spacing between detects, overlap mode: PAT_LEN minus the longest proper border of `PATTERN`. For `1011` this is 3 cycles.
- Reset asserted in the cycle following a detect edge: `Out` drops at that reset edge.
- Reset is honoured every cycle; there is no initialization period.

## Structure
- Shared package `seq_det_pkg`:
  - state enum/encoding helper, width $clog2(PAT_LEN+1);
  - a constant function computing the next-state table from `PATTERN`, `PAT_LEN` and `OVERLAP`.
- Single module `seq_det`:
  - state register;
  - next-state lookup indexed by {state, `In`};
  - output decode.
- No sub-modules.
- Parameter checks at elaboration: `PAT_LEN` in range, and `PATTERN` width equals `PAT_LEN`.

## Test plan
- Reset: hold `rst`=1 for 3 edges with random `In` → `Out`=0 throughout; state `M0`.
- Single match, default parameters: after reset, drive 1,0,1,1 → `Out`=1 for exactly the one cycle after the 4th edge, then 0.
- Overlap: drive 1,0,1,1,0,1,1 → `Out` pulses after edges 4 and 7. With `OVERLAP`=0, same stream → pulse after edge 4 only.
- Fallback paths: drive 1,1,0,1,0,1,1 → no false detect before edge 7, one pulse after edge 7 (exercises `M1`→`M1` and `M3`→`M2`).
- Reset mid-match: drive 1,0,1, assert `rst` at the next edge, then 1 → no detect. Then 1,0,1,1 → pulse.
- Random: 500 random bits, including input changes between edges → `Out` matches a reference model that compares the last 4 sampled bits against 1011, one cycle late; zero mismatches.
